// File: rtl/mem_seq_ctrl.sv
// Sequences EXE/MEM loads, 32-bit stores and 64-bit stores (as two 32-bit beats) onto a
// single-beat data memory port; 2 cycles min per 32-bit access, 3 per 64-bit; Stall holds the pipe until the last beat.
module mem_seq_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemWrite64,
   input  logic [31:0] Adrs_MEM,
   input  logic [31:0] Rt_data_MEM,
   input  logic [63:0] Rt_data64_MEM,
   input  logic        Mem_ready,
   input  logic [31:0] Mem_rdata,
   output logic        Mem_req,
   output logic        Mem_we,
   output logic [31:0] Mem_addr,
   output logic [31:0] Mem_wdata,
   output logic        Stall,
   output logic [31:0] Rdata_MEM,
   output logic        Align_err,
   output logic        Timeout_err
);

   localparam logic [3:0] TO_CNT = 4'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_W64L = 3'd3,
      S_W64H = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] adrs_q, adrs_d;
   logic [31:0] wdata_q, wdata_d;
   logic [63:0] wdata64_q, wdata64_d;
   logic [31:0] rdata_q, rdata_d;

   logic req_any;
   logic misalign;
   logic in_beat;
   logic timed_out;

   assign req_any   = MemRead | MemWrite | MemWrite64;
   assign misalign  = MemWrite64 & (Adrs_MEM[2:0] != 3'd0);
   assign in_beat   = (state_q != S_IDLE);
   assign timed_out = in_beat & ~Mem_ready & (wait_cnt_q == TO_CNT);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= 4'd0;
         adrs_q     <= 32'd0;
         wdata_q    <= 32'd0;
         wdata64_q  <= 64'd0;
         rdata_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         adrs_q     <= adrs_d;
         wdata_q    <= wdata_d;
         wdata64_q  <= wdata64_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (MemWrite64) begin
               if (!misalign) state_d = S_W64L;
            end else if (MemWrite) begin
               state_d = S_WR;
            end else if (MemRead) begin
               state_d = S_RD;
            end
         end
         S_W64L: begin
            if (Mem_ready)      state_d = S_W64H;
            else if (timed_out) state_d = S_IDLE;
         end
         S_RD, S_WR, S_W64H: begin
            if (Mem_ready || timed_out) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Every beat entry follows either IDLE or a completed beat, so clearing on those covers entry.
   always_comb begin
      wait_cnt_d = 4'd0;
      if (in_beat && !Mem_ready && !timed_out) wait_cnt_d = wait_cnt_q + 4'd1;

      adrs_d    = adrs_q;
      wdata_d   = wdata_q;
      wdata64_d = wdata64_q;
      if (state_q == S_IDLE && req_any) begin
         adrs_d    = Adrs_MEM;
         wdata_d   = Rt_data_MEM;
         wdata64_d = Rt_data64_MEM;
      end

      rdata_d = rdata_q;
      if (state_q == S_RD && Mem_ready) rdata_d = Mem_rdata;
   end

   always_comb begin
      Mem_req     = 1'b0;
      Mem_we      = 1'b0;
      Mem_addr    = adrs_q;
      Mem_wdata   = 32'd0;
      Stall       = 1'b0;
      Align_err   = 1'b0;
      Timeout_err = 1'b0;
      case (state_q)
         S_IDLE: begin
            Align_err = misalign;
            Stall     = req_any & ~misalign;
         end
         S_RD: begin
            Mem_req     = 1'b1;
            Stall       = ~Mem_ready & ~timed_out;
            Timeout_err = timed_out;
         end
         S_WR: begin
            Mem_req     = 1'b1;
            Mem_we      = 1'b1;
            Mem_wdata   = wdata_q;
            Stall       = ~Mem_ready & ~timed_out;
            Timeout_err = timed_out;
         end
         S_W64L: begin
            Mem_req     = 1'b1;
            Mem_we      = 1'b1;
            Mem_wdata   = wdata64_q[31:0];
            Stall       = ~timed_out;
            Timeout_err = timed_out;
         end
         S_W64H: begin
            Mem_req     = 1'b1;
            Mem_we      = 1'b1;
            Mem_addr    = adrs_q + 32'd4;
            Mem_wdata   = wdata64_q[63:32];
            Stall       = ~Mem_ready & ~timed_out;
            Timeout_err = timed_out;
         end
         default: ;
      endcase
   end

   assign Rdata_MEM = rdata_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Bench for mem_seq_ctrl: directed vectors plus random traffic against a beat-queue reference model.
module tb_mem_seq_ctrl;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        Reset;
   logic        MemRead, MemWrite, MemWrite64;
   logic [31:0] Adrs_MEM, Rt_data_MEM;
   logic [63:0] Rt_data64_MEM;
   logic        Mem_ready;
   logic [31:0] Mem_rdata;
   logic        Mem_req, Mem_we;
   logic [31:0] Mem_addr, Mem_wdata;
   logic        Stall;
   logic [31:0] Rdata_MEM;
   logic        Align_err, Timeout_err;

   always #5 clk = ~clk;

   mem_seq_ctrl #(.TIMEOUT(TO)) dut (
      .Clk          (clk),
      .Reset        (Reset),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .MemWrite64   (MemWrite64),
      .Adrs_MEM     (Adrs_MEM),
      .Rt_data_MEM  (Rt_data_MEM),
      .Rt_data64_MEM(Rt_data64_MEM),
      .Mem_ready    (Mem_ready),
      .Mem_rdata    (Mem_rdata),
      .Mem_req      (Mem_req),
      .Mem_we       (Mem_we),
      .Mem_addr     (Mem_addr),
      .Mem_wdata    (Mem_wdata),
      .Stall        (Stall),
      .Rdata_MEM    (Rdata_MEM),
      .Align_err    (Align_err),
      .Timeout_err  (Timeout_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the pending access is a queue of beats still to be performed.
   typedef struct {
      logic [31:0] a;
      logic        we;
      logic [31:0] d;
   } beat_t;

   beat_t       beats[$];
   int          waits   = 0;
   logic [31:0] m_rdata = 32'd0;

   int req_cycles = 0;
   int terr_seen  = 0;
   int aerr_seen  = 0;

   task automatic step(input logic rd, input logic wr, input logic w64,
                       input logic [31:0] a, input logic [31:0] d32, input logic [63:0] d64,
                       input logic rdy, input logic [31:0] rdat, input logic rst);
      logic        e_req, e_we, e_stall, e_aerr, e_terr;
      logic [31:0] e_addr, e_wdata;
      bit          to;
      beat_t       b;
      @(negedge clk);
      Reset = rst; MemRead = rd; MemWrite = wr; MemWrite64 = w64;
      Adrs_MEM = a; Rt_data_MEM = d32; Rt_data64_MEM = d64;
      Mem_ready = rdy; Mem_rdata = rdat;
      #1;
      e_req = 0; e_we = 0; e_stall = 0; e_aerr = 0; e_terr = 0;
      e_addr = 0; e_wdata = 0; to = 0;
      if (beats.size() > 0) begin
         to      = !rdy && (waits == TO);
         e_req   = 1;
         e_we    = beats[0].we;
         e_addr  = beats[0].a;
         e_wdata = beats[0].d;
         e_terr  = to;
         e_stall = !(rdy && beats.size() == 1) && !to;
      end else if (w64) begin
         e_aerr  = (a % 8) != 0;
         e_stall = !e_aerr;
      end else begin
         e_stall = wr || rd;
      end
      if (!rst) begin
         check("mem_req", Mem_req, e_req);
         check("mem_we", Mem_we, e_we);
         if (e_req) begin
            check("mem_addr", Mem_addr, e_addr);
            check("mem_wdata", Mem_wdata, e_wdata);
         end
         check("stall", Stall, e_stall);
         check("align_err", Align_err, e_aerr);
         check("timeout_err", Timeout_err, e_terr);
         check("rdata_mem", Rdata_MEM, m_rdata);
         if (Mem_req) req_cycles++;
         if (Timeout_err) terr_seen++;
         if (Align_err) aerr_seen++;
      end
      @(posedge clk);
      if (rst) begin
         beats.delete();
         waits   = 0;
         m_rdata = 0;
      end else if (beats.size() > 0) begin
         if (rdy) begin
            if (!beats[0].we) m_rdata = rdat;
            void'(beats.pop_front());
            waits = 0;
         end else if (to) begin
            beats.delete();
            waits = 0;
         end else begin
            waits++;
         end
      end else begin
         waits = 0;
         if (w64) begin
            if (a % 8 == 0) begin
               b.a = a;     b.we = 1; b.d = d64[31:0];  beats.push_back(b);
               b.a = a + 4; b.we = 1; b.d = d64[63:32]; beats.push_back(b);
            end
         end else if (wr) begin
            b.a = a; b.we = 1; b.d = d32; beats.push_back(b);
         end else if (rd) begin
            b.a = a; b.we = 0; b.d = 0; beats.push_back(b);
         end
      end
   endtask

   task automatic idle(input logic rdy);
      step(0, 0, 0, 32'd0, 32'd0, 64'd0, rdy, 32'd0, 0);
   endtask

   initial begin
      logic [31:0] a;
      int          rdy_pct;
      Reset = 1; MemRead = 0; MemWrite = 0; MemWrite64 = 0;
      Adrs_MEM = 0; Rt_data_MEM = 0; Rt_data64_MEM = 0; Mem_ready = 0; Mem_rdata = 0;

      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);

      // Single read, ready at once.
      step(1, 0, 0, 32'h100, 0, 0, 1, 32'hDEADBEEF, 0);
      step(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
      #1 check("rd_result", Rdata_MEM, 32'hDEADBEEF);
      idle(1);

      // Aligned 64-bit store.
      step(0, 0, 1, 32'h200, 0, 64'h11112222_33334444, 1, 0, 0);
      idle(1);
      idle(1);

      // Misaligned 64-bit store is dropped.
      aerr_seen  = 0;
      req_cycles = 0;
      step(0, 0, 1, 32'h204, 0, 64'h55556666_77778888, 1, 0, 0);
      idle(1);
      check("align_pulses", aerr_seen, 1);
      check("align_no_beat", req_cycles, 0);

      // Write that never gets ready.
      req_cycles = 0;
      terr_seen  = 0;
      step(0, 1, 0, 32'h300, 32'hCAFEF00D, 0, 0, 0, 0);
      repeat (18) idle(0);
      check("timeout_req_cycles", req_cycles, 16);
      check("timeout_pulses", terr_seen, 1);

      // Write wins over read.
      step(1, 1, 0, 32'h400, 32'h0BADF00D, 0, 1, 32'h12345678, 0);
      idle(1);
      #1 check("prio_no_read", Rdata_MEM, 32'hDEADBEEF);

      // Reset during the high beat of a 64-bit store.
      step(0, 0, 1, 32'h200, 0, 64'h11112222_33334444, 1, 0, 0);
      idle(1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      #1 check("reset_rdata", Rdata_MEM, 32'd0);

      // Random traffic with varying memory readiness and occasional reset.
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) rdy_pct = (i / 500) % 3 == 0 ? 90 : ((i / 500) % 3 == 1 ? 40 : 8);
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
         step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 20),
              a, $urandom, {$urandom, $urandom},
              ($urandom_range(0, 99) < rdy_pct), $urandom,
              ($urandom_range(0, 299) == 0));
      end
      idle(1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
